// File: rtl/player_motion_controller.sv
// player_motion_controller: per-player button-driven motion with speed ramping,
// edge clamping, a shared movement tick, pause and recenter.
module player_motion_controller #(
  parameter int NUM_PLAYERS   = 2,
  parameter int POS_W         = 10,
  parameter int FIELD_W       = 640,
  parameter int FIELD_H       = 480,
  parameter int PLAYER_RADIUS = 16,
  parameter int INIT_Y        = 240,
  parameter int INIT_X_EVEN   = 100,
  parameter int INIT_X_ODD    = 540,
  parameter int TICK_DIV      = 833333,
  parameter int MAX_STEP      = 4,
  parameter int RAMP_TICKS    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pause,
  input  logic                         recenter,
  input  logic [NUM_PLAYERS-1:0]       btn_up,
  input  logic [NUM_PLAYERS-1:0]       btn_down,
  input  logic [NUM_PLAYERS-1:0]       btn_left,
  input  logic [NUM_PLAYERS-1:0]       btn_right,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_x,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_y,
  output logic [NUM_PLAYERS-1:0]       moving,
  output logic                         tick
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int SPD_W = $clog2(MAX_STEP + 1);
  localparam int RMP_W = $clog2(RAMP_TICKS + 1);
  localparam int EXT_W = POS_W + 2;
  localparam logic signed [EXT_W-1:0] LO   = EXT_W'(PLAYER_RADIUS);
  localparam logic signed [EXT_W-1:0] HI_X = EXT_W'(FIELD_W - 1 - PLAYER_RADIUS);
  localparam logic signed [EXT_W-1:0] HI_Y = EXT_W'(FIELD_H - 1 - PLAYER_RADIUS);

  typedef enum logic [1:0] {S_IDLE, S_RAMP, S_CRUISE} state_t;

  function automatic logic [POS_W-1:0] clamp(input logic signed [EXT_W-1:0] v,
                                             input logic signed [EXT_W-1:0] hi);
    return (v < LO) ? POS_W'(LO) : (v > hi) ? POS_W'(hi) : POS_W'(v);
  endfunction

  logic [CNT_W-1:0]         r_cnt;
  logic                     r_tick;
  logic [4*NUM_PLAYERS-1:0] r_s1, r_s2;

  assign tick = r_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_s1   <= '0;
      r_s2   <= '0;
    end else begin
      r_s1   <= {btn_up, btn_down, btn_left, btn_right};
      r_s2   <= r_s1;
      r_tick <= !recenter && !pause && (r_cnt == CNT_W'(TICK_DIV - 1));
      if (recenter)
        r_cnt <= '0;
      else if (!pause)
        r_cnt <= (r_cnt == CNT_W'(TICK_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pl
    localparam logic [POS_W-1:0] INIT_X = POS_W'((g % 2 == 0) ? INIT_X_EVEN : INIT_X_ODD);
    localparam logic [POS_W-1:0] INIT_YV = POS_W'(INIT_Y);
    logic [POS_W-1:0]        r_x, r_y;
    state_t                  r_st;
    logic [SPD_W-1:0]        r_spd;
    logic [RMP_W-1:0]        r_rc;
    logic [1:0]              r_pdx, r_pdy;
    logic                    r_mv;
    logic                    w_u, w_d, w_l, w_r, w_active, w_chg;
    logic [1:0]              w_dx, w_dy;
    logic [SPD_W-1:0]        w_spd;
    logic signed [EXT_W-1:0] w_mag, w_dltx, w_dlty, w_nx, w_ny;

    always_comb begin
      w_u      = r_s2[3*NUM_PLAYERS + g];
      w_d      = r_s2[2*NUM_PLAYERS + g];
      w_l      = r_s2[NUM_PLAYERS + g];
      w_r      = r_s2[g];
      w_dx     = (w_l & ~w_r) ? 2'b11 : (w_r & ~w_l) ? 2'b01 : 2'b00;
      w_dy     = (w_u & ~w_d) ? 2'b11 : (w_d & ~w_u) ? 2'b01 : 2'b00;
      w_active = |{w_dx, w_dy};
      w_chg    = (r_st != S_IDLE) && ({w_dx, w_dy} != {r_pdx, r_pdy});
      w_spd    = w_chg ? SPD_W'(1) : r_spd;
      w_mag    = {{(EXT_W-SPD_W){1'b0}}, w_spd};
      w_dltx   = w_dx[1] ? -w_mag : w_dx[0] ? w_mag : '0;
      w_dlty   = w_dy[1] ? -w_mag : w_dy[0] ? w_mag : '0;
      w_nx     = $signed({2'b00, r_x}) + w_dltx;
      w_ny     = $signed({2'b00, r_y}) + w_dlty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || recenter) begin
        r_x   <= INIT_X;
        r_y   <= INIT_YV;
        r_st  <= S_IDLE;
        r_spd <= SPD_W'(1);
        r_rc  <= '0;
        r_pdx <= '0;
        r_pdy <= '0;
        r_mv  <= 1'b0;
      end else if (r_tick) begin
        r_x   <= clamp(w_nx, HI_X);
        r_y   <= clamp(w_ny, HI_Y);
        r_pdx <= w_dx;
        r_pdy <= w_dy;
        r_mv  <= w_active;
        if (!w_active) begin
          r_st  <= S_IDLE;
          r_spd <= SPD_W'(1);
          r_rc  <= '0;
        end else if (w_chg) begin
          r_st  <= (MAX_STEP == 1) ? S_CRUISE : S_RAMP;
          r_spd <= SPD_W'(1);
          r_rc  <= '0;
        end else if (r_spd == SPD_W'(MAX_STEP)) begin
          r_st <= S_CRUISE;
        end else if (r_rc == RMP_W'(RAMP_TICKS - 1)) begin
          // the speed bump takes effect on the following tick
          r_spd <= r_spd + 1'b1;
          r_rc  <= '0;
          r_st  <= (r_spd == SPD_W'(MAX_STEP - 1)) ? S_CRUISE : S_RAMP;
        end else begin
          r_rc <= r_rc + 1'b1;
          r_st <= S_RAMP;
        end
      end
    end

    assign pos_x[g*POS_W +: POS_W] = r_x;
    assign pos_y[g*POS_W +: POS_W] = r_y;
    assign moving[g]               = r_mv;
  end
endmodule

// File: tb/tb_player_motion_controller.sv
// tb_player_motion_controller: directed scenarios plus randomized buttons/pause/recenter,
// checked every cycle against a tick-level arithmetic model of the players.
module tb_player_motion_controller;
  localparam int NP = 2, PW = 10, TD = 4, MS = 4, RT = 2;
  localparam int LO = 16, HX = 623, HY = 463;

  logic clk = 0, rst_n = 0, pause = 0, recenter = 0;
  logic [NP-1:0] btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0;
  logic [NP*PW-1:0] pos_x, pos_y;
  logic [NP-1:0] moving;
  logic tick;
  int n_chk = 0, n_err = 0, cyc = 0;

  player_motion_controller #(
    .NUM_PLAYERS(NP), .POS_W(PW), .TICK_DIV(TD), .MAX_STEP(MS), .RAMP_TICKS(RT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pause(pause), .recenter(recenter),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .pos_x(pos_x), .pos_y(pos_y), .moving(moving), .tick(tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  int mx[NP], my[NP], spd[NP], held[NP], ldx[NP], ldy[NP];
  bit mact[NP], mmv[NP], mtick;
  int run;
  logic [4*NP-1:0] q[$];

  function automatic int clampi(int v, int lo, int hi);
    return v < lo ? lo : (v > hi ? hi : v);
  endfunction

  task automatic m_home();
    for (int i = 0; i < NP; i++) begin
      mx[i] = (i % 2 == 0) ? 100 : 540;
      my[i] = 240;
      spd[i] = 1; held[i] = 0; ldx[i] = 0; ldy[i] = 0;
      mact[i] = 0; mmv[i] = 0;
    end
    run = 0;
    mtick = 0;
  endtask

  task automatic m_step();
    logic [4*NP-1:0] eff;
    int dx, dy, s;
    q.push_back({btn_up, btn_down, btn_left, btn_right});
    eff = q.pop_front();
    if (recenter) begin
      m_home();
      return;
    end
    if (mtick)
      for (int i = 0; i < NP; i++) begin
        dx = int'(eff[i]) - int'(eff[NP + i]);
        dy = int'(eff[2*NP + i]) - int'(eff[3*NP + i]);
        if (dx == 0 && dy == 0) begin
          mmv[i] = 0; mact[i] = 0; spd[i] = 1; held[i] = 0; ldx[i] = 0; ldy[i] = 0;
        end else begin
          if (mact[i] && (dx != ldx[i] || dy != ldy[i])) begin
            s = 1; spd[i] = 1; held[i] = 0;
          end else begin
            s = spd[i];
            if (spd[i] < MS) begin
              held[i]++;
              if (held[i] == RT) begin spd[i]++; held[i] = 0; end
            end
          end
          mx[i] = clampi(mx[i] + dx * s, LO, HX);
          my[i] = clampi(my[i] + dy * s, LO, HY);
          ldx[i] = dx; ldy[i] = dy; mact[i] = 1; mmv[i] = 1;
        end
      end
    if (pause) mtick = 0;
    else begin
      run++;
      mtick = (run % TD) == 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_home();
      q = '{'0, '0};
    end else m_step();
  end

  always @(negedge clk) begin
    for (int i = 0; i < NP; i++) begin
      check("pos_x", int'(pos_x[i*PW +: PW]), mx[i]);
      check("pos_y", int'(pos_y[i*PW +: PW]), my[i]);
      check("moving", int'(moving[i]), int'(mmv[i]));
    end
    check("tick", int'(tick), int'(mtick));
  end

  task automatic step_in();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = tick;
    end
    if (!seen) check("tick_timeout", 0, 1);
  endtask

  task automatic pulse_recenter();
    step_in();
    recenter = 1;
    step_in();
    recenter = 0;
  endtask

  int exp_y[8] = '{239, 238, 236, 234, 231, 228, 224, 220};
  int t_prev, y_hold;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_x0", int'(pos_x[9:0]), 100);
    check("rst_x1", int'(pos_x[19:10]), 540);
    check("rst_y0", int'(pos_y[9:0]), 240);
    check("rst_mv", int'(moving), 0);
    check("rst_tick", int'(tick), 0);
    step_in();
    rst_n = 1;
    btn_up[0] = 1;
    for (int k = 0; k < 8; k++) begin
      wait_tick();
      if (k > 0) check("tick_period", cyc - t_prev, TD);
      t_prev = cyc;
      @(negedge clk);
      check("ramp_y0", int'(pos_y[9:0]), exp_y[k]);
      check("idle_y1", int'(pos_y[19:10]), 240);
    end
    for (int k = 0; k < 100 && pos_y[9:0] != 16; k++) begin
      wait_tick();
      @(negedge clk);
    end
    for (int k = 0; k < 2; k++) begin
      wait_tick();
      @(negedge clk);
      check("clamp_y0", int'(pos_y[9:0]), 16);
      check("clamp_mv0", int'(moving[0]), 1);
    end
    step_in();
    btn_left[1] = 1;
    btn_right[1] = 1;
    repeat (3) wait_tick();
    @(negedge clk);
    check("lr_x1", int'(pos_x[19:10]), 540);
    check("lr_mv1", int'(moving[1]), 0);
    step_in();
    btn_left[1] = 0;
    btn_right[1] = 0;
    pulse_recenter();
    repeat (3) wait_tick();
    @(negedge clk);
    check("pre_pause_y0", int'(pos_y[9:0]), 236);
    step_in();
    pause = 1;
    y_hold = int'(pos_y[9:0]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("pause_tick", int'(tick), 0);
      check("pause_y0", int'(pos_y[9:0]), y_hold);
    end
    step_in();
    pause = 0;
    wait_tick();
    @(negedge clk);
    check("resume_y0", int'(pos_y[9:0]), 234);
    wait_tick();
    @(negedge clk);
    check("resume2_y0", int'(pos_y[9:0]), 231);
    pulse_recenter();
    repeat (4) wait_tick();
    #2;
    rst_n = 0;
    @(negedge clk);
    check("mid_rst_x0", int'(pos_x[9:0]), 100);
    check("mid_rst_x1", int'(pos_x[19:10]), 540);
    check("mid_rst_y0", int'(pos_y[9:0]), 240);
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_mv", int'(moving), 0);
    step_in();
    rst_n = 1;
    wait_tick();
    @(negedge clk);
    check("post_rst_y0", int'(pos_y[9:0]), 239);
    for (int c = 0; c < 4000; c++) begin
      step_in();
      for (int b = 0; b < NP; b++) begin
        if ($urandom_range(0, 15) == 0) btn_up[b] = ~btn_up[b];
        if ($urandom_range(0, 15) == 0) btn_down[b] = ~btn_down[b];
        if ($urandom_range(0, 15) == 0) btn_left[b] = ~btn_left[b];
        if ($urandom_range(0, 15) == 0) btn_right[b] = ~btn_right[b];
      end
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      recenter = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
    end
    step_in();
    rst_n = 1;
    recenter = 0;
    pause = 0;
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
